// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the hazard sequencer (slave) and the datapath it steers (master).
interface pipeline_hazard_ctrl_if #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int PERF_CNT_BITS       = 16
);
    logic                           idValid;
    logic [REG_INDEX_BIT_WIDTH-1:0] idRdIndex1;
    logic [REG_INDEX_BIT_WIDTH-1:0] idRdIndex2;
    logic                           idUsesRd2;
    logic                           exIsLoad;
    logic [REG_INDEX_BIT_WIDTH-1:0] exWrtIndex;
    logic                           exRedirect;
    logic                           extHold;
    logic                           pcWrtEn;
    logic                           ifIdWrtEn;
    logic                           ifIdFlush;
    logic                           idExBubble;
    logic [PERF_CNT_BITS-1:0]       stallCount;
    logic [PERF_CNT_BITS-1:0]       flushCount;
    logic [PERF_CNT_BITS-1:0]       holdCount;

    modport master (
        output idValid, idRdIndex1, idRdIndex2, idUsesRd2,
               exIsLoad, exWrtIndex, exRedirect, extHold,
        input  pcWrtEn, ifIdWrtEn, ifIdFlush, idExBubble,
               stallCount, flushCount, holdCount
    );

    modport slave (
        input  idValid, idRdIndex1, idRdIndex2, idUsesRd2,
               exIsLoad, exWrtIndex, exRedirect, extHold,
        output pcWrtEn, ifIdWrtEn, ifIdFlush, idExBubble,
               stallCount, flushCount, holdCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / redirect / hold sequencer driving PC, IF/ID and ID/EX controls.
// Performance counters exist only when PIPE_HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int FLUSH_CYCLES        = 2,
    parameter int PERF_CNT_BITS       = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, LSTALL, FLUSH, HOLD} state_t;
    typedef enum logic [1:0] {OUT_RUN, OUT_STALL, OUT_FLUSH, OUT_FREEZE} out_t;

    localparam logic [1:0] STALL_RELOAD = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;
    localparam logic [1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    state_t                         state, state_next;
    logic [1:0]                     cnt, cnt_next;
    out_t                           oset;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd1, rd2, wr;
    logic                           lu_haz;

    assign rd1    = bus.idRdIndex1;
    assign rd2    = bus.idRdIndex2;
    assign wr     = bus.exWrtIndex;
    assign lu_haz = bus.idValid & bus.exIsLoad & ((wr == rd1) | (bus.idUsesRd2 & (wr == rd2)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Redirect is handled identically from every state; HOLD with extHold low acts as RUN
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        oset       = OUT_RUN;
        if (bus.extHold) begin
            oset       = OUT_FREEZE;
            state_next = HOLD;
        end else if (bus.exRedirect) begin
            oset = OUT_FLUSH;
            if (FLUSH_CYCLES > 1) begin
                state_next = FLUSH;
                cnt_next   = FLUSH_RELOAD;
            end else begin
                state_next = RUN;
            end
        end else begin
            case (state)
                LSTALL: begin
                    oset = OUT_STALL;
                    if (cnt == 2'd0) state_next = RUN;
                    else             cnt_next   = cnt - 2'd1;
                end
                FLUSH: begin
                    oset = OUT_FLUSH;
                    if (cnt == 2'd0) state_next = RUN;
                    else             cnt_next   = cnt - 2'd1;
                end
                default: begin
                    state_next = RUN;
                    if (lu_haz) begin
                        oset = OUT_STALL;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_next = LSTALL;
                            cnt_next   = STALL_RELOAD;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.pcWrtEn    = 1'b1;
        bus.ifIdWrtEn  = 1'b1;
        bus.ifIdFlush  = 1'b0;
        bus.idExBubble = 1'b0;
        if (!reset) begin
            bus.pcWrtEn    = 1'b0;
            bus.ifIdWrtEn  = 1'b0;
            bus.ifIdFlush  = 1'b1;
            bus.idExBubble = 1'b1;
        end else begin
            case (oset)
                OUT_STALL: begin
                    bus.pcWrtEn    = 1'b0;
                    bus.ifIdWrtEn  = 1'b0;
                    bus.idExBubble = 1'b1;
                end
                OUT_FLUSH: begin
                    bus.ifIdFlush  = 1'b1;
                    bus.idExBubble = 1'b1;
                end
                OUT_FREEZE: begin
                    bus.pcWrtEn   = 1'b0;
                    bus.ifIdWrtEn = 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    function automatic logic [PERF_CNT_BITS-1:0] sat_inc(input logic [PERF_CNT_BITS-1:0] v,
                                                         input logic en);
        return (en && (v != {PERF_CNT_BITS{1'b1}})) ? v + PERF_CNT_BITS'(1) : v;
    endfunction

    logic [PERF_CNT_BITS-1:0] stall_cnt, flush_cnt, hold_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, oset == OUT_STALL);
            flush_cnt <= sat_inc(flush_cnt, oset == OUT_FLUSH);
            hold_cnt  <= sat_inc(hold_cnt,  oset == OUT_FREEZE);
        end
    end

    assign bus.stallCount = stall_cnt;
    assign bus.flushCount = flush_cnt;
    assign bus.holdCount  = hold_cnt;
`else
    assign bus.stallCount = {PERF_CNT_BITS{1'b0}};
    assign bus.flushCount = {PERF_CNT_BITS{1'b0}};
    assign bus.holdCount  = {PERF_CNT_BITS{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances (LOAD_STALL_CYCLES 1/2/3, the last
// with 3-bit counters) share one stimulus stream and are checked against hand-computed values.
module tb_pipeline_hazard_ctrl;
    localparam logic [3:0] S_RUN   = 4'b1100;
    localparam logic [3:0] S_STALL = 4'b0001;
    localparam logic [3:0] S_FLUSH = 4'b1111;
    localparam logic [3:0] S_FRZ   = 4'b0000;
    localparam logic [3:0] S_RST   = 4'b0011;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       idValid, idUsesRd2, exIsLoad, exRedirect, extHold;
    logic [3:0] rs1, rs2, wr;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_INDEX_BIT_WIDTH(4), .PERF_CNT_BITS(16)) ifa ();
    pipeline_hazard_ctrl_if #(.REG_INDEX_BIT_WIDTH(4), .PERF_CNT_BITS(16)) ifb ();
    pipeline_hazard_ctrl_if #(.REG_INDEX_BIT_WIDTH(4), .PERF_CNT_BITS(3))  ifc ();

    assign ifa.idValid = idValid;  assign ifb.idValid = idValid;  assign ifc.idValid = idValid;
    assign ifa.idRdIndex1 = rs1;   assign ifb.idRdIndex1 = rs1;   assign ifc.idRdIndex1 = rs1;
    assign ifa.idRdIndex2 = rs2;   assign ifb.idRdIndex2 = rs2;   assign ifc.idRdIndex2 = rs2;
    assign ifa.idUsesRd2 = idUsesRd2; assign ifb.idUsesRd2 = idUsesRd2; assign ifc.idUsesRd2 = idUsesRd2;
    assign ifa.exIsLoad = exIsLoad; assign ifb.exIsLoad = exIsLoad; assign ifc.exIsLoad = exIsLoad;
    assign ifa.exWrtIndex = wr;    assign ifb.exWrtIndex = wr;    assign ifc.exWrtIndex = wr;
    assign ifa.exRedirect = exRedirect; assign ifb.exRedirect = exRedirect; assign ifc.exRedirect = exRedirect;
    assign ifa.extHold = extHold;  assign ifb.extHold = extHold;  assign ifc.extHold = extHold;

    pipeline_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(4), .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2),
                           .PERF_CNT_BITS(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    pipeline_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(4), .LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2),
                           .PERF_CNT_BITS(16)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    pipeline_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(4), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2),
                           .PERF_CNT_BITS(3))  dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    logic [3:0]  o  [3];
    logic [31:0] sc [3];
    logic [31:0] fc [3];
    logic [31:0] hc [3];

    assign o[0] = {ifa.pcWrtEn, ifa.ifIdWrtEn, ifa.ifIdFlush, ifa.idExBubble};
    assign o[1] = {ifb.pcWrtEn, ifb.ifIdWrtEn, ifb.ifIdFlush, ifb.idExBubble};
    assign o[2] = {ifc.pcWrtEn, ifc.ifIdWrtEn, ifc.ifIdFlush, ifc.idExBubble};
    assign sc[0] = 32'(ifa.stallCount); assign sc[1] = 32'(ifb.stallCount); assign sc[2] = 32'(ifc.stallCount);
    assign fc[0] = 32'(ifa.flushCount); assign fc[1] = 32'(ifb.flushCount); assign fc[2] = 32'(ifc.flushCount);
    assign hc[0] = 32'(ifa.holdCount);  assign hc[1] = 32'(ifb.holdCount);  assign hc[2] = 32'(ifc.holdCount);

    // Counters read as zero in a build without the perf-counter macro
    function automatic logic [31:0] cexp(input int v);
        if (v < 0) return 32'd0;
`ifdef PIPE_HAZARD_PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0;
`endif
    endfunction

    task automatic set_in(input logic v, input logic [3:0] r1, input logic [3:0] r2, input logic u2,
                          input logic ld, input logic [3:0] w, input logic rd, input logic hold);
        idValid = v; rs1 = r1; rs2 = r2; idUsesRd2 = u2;
        exIsLoad = ld; wr = w; exRedirect = rd; extHold = hold;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] e [3];
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        e = '{S_RST, S_RST, S_RST};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rst_outs dut%0d: got %b want %b", k, o[k], e[k]); end
            checks++;
            if ({sc[k], fc[k], hc[k]} !== 96'd0) begin errors++; $display("FAIL rst_counts dut%0d: got %0d/%0d/%0d want 0/0/0", k, sc[k], fc[k], hc[k]); end
        end
        tick();
        reset = 1'b1;
        #1;
        e = '{S_RUN, S_RUN, S_RUN};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rst_release dut%0d: got %b want %b", k, o[k], e[k]); end
        end
    endtask

    task automatic test_load_use();
        logic [3:0] e [3];
        int x [3];
        apply_reset();
        set_in(1, 3, 0, 0, 1, 3, 0, 0);
        #1;
        e = '{S_STALL, S_STALL, S_STALL};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL lu_c1 dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        e = '{S_RUN, S_STALL, S_STALL};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL lu_c2 dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        e = '{S_RUN, S_RUN, S_STALL};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL lu_c3 dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        e = '{S_RUN, S_RUN, S_RUN};
        x = '{1, 2, 3};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL lu_c4 dut%0d: got %b want %b", k, o[k], e[k]); end
            checks++;
            if (sc[k] !== cexp(x[k])) begin errors++; $display("FAIL lu_stallCount dut%0d: got %0d want %0d", k, sc[k], cexp(x[k])); end
        end
    endtask

    task automatic test_rd2();
        logic [3:0] e [3];
        apply_reset();
        set_in(1, 1, 5, 0, 1, 5, 0, 0);
        #1;
        e = '{S_RUN, S_RUN, S_RUN};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rd2_unused dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rd2_novalid dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        set_in(1, 1, 5, 1, 1, 5, 0, 0);
        #1;
        e = '{S_STALL, S_STALL, S_STALL};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rd2_used dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        set_in(1, 0, 7, 0, 1, 0, 0, 0);
        #1;
        e = '{S_STALL, S_STALL, S_STALL};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rd_zero dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_redirect();
        logic [3:0] e [3];
        apply_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        e = '{S_FLUSH, S_FLUSH, S_FLUSH};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rdr_c1 dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rdr_c2 dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        e = '{S_RUN, S_RUN, S_RUN};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rdr_c3 dut%0d: got %b want %b", k, o[k], e[k]); end
            checks++;
            if (fc[k] !== cexp(2)) begin errors++; $display("FAIL rdr_flushCount dut%0d: got %0d want %0d", k, fc[k], cexp(2)); end
        end
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        #1;
        e = '{S_FLUSH, S_FLUSH, S_FLUSH};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rdr2_c2 dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rdr2_c3 dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        e = '{S_RUN, S_RUN, S_RUN};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL rdr2_c4 dut%0d: got %b want %b", k, o[k], e[k]); end
            checks++;
            if (fc[k] !== cexp(5)) begin errors++; $display("FAIL rdr2_flushCount dut%0d: got %0d want %0d", k, fc[k], cexp(5)); end
        end
    endtask

    task automatic test_priority();
        logic [3:0] e [3];
        apply_reset();
        set_in(1, 3, 0, 0, 1, 3, 1, 0);
        #1;
        e = '{S_FLUSH, S_FLUSH, S_FLUSH};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL pri_rdr_lu dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sc[k] !== cexp(0)) begin errors++; $display("FAIL pri_stallCount dut%0d: got %0d want %0d", k, sc[k], cexp(0)); end
        end
        set_in(1, 3, 0, 0, 1, 3, 1, 1);
        #1;
        e = '{S_FRZ, S_FRZ, S_FRZ};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL pri_hold_c1 dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        tick();
        extHold = 1'b0;
        #1;
        e = '{S_FLUSH, S_FLUSH, S_FLUSH};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL pri_resume dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({sc[k], fc[k], hc[k]} !== {cexp(0), cexp(4), cexp(2)}) begin
                errors++;
                $display("FAIL pri_counts dut%0d: got %0d/%0d/%0d want %0d/%0d/%0d", k, sc[k], fc[k], hc[k], cexp(0), cexp(4), cexp(2));
            end
        end
    endtask

    task automatic test_hold_lstall();
        logic [3:0] e [3];
        apply_reset();
        set_in(1, 3, 0, 0, 1, 3, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 5; c++) begin
            #1;
            e = '{S_FRZ, S_FRZ, S_FRZ};
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (o[k] !== e[k]) begin errors++; $display("FAIL hold_c%0d dut%0d: got %b want %b", c, k, o[k], e[k]); end
            end
            tick();
        end
        extHold = 1'b0;
        #1;
        e = '{S_RUN, S_RUN, S_RUN};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL hold_release dut%0d: got %b want %b", k, o[k], e[k]); end
            checks++;
            if ({sc[k], hc[k]} !== {cexp(1), cexp(5)}) begin
                errors++;
                $display("FAIL hold_counts dut%0d: got %0d/%0d want %0d/%0d", k, sc[k], hc[k], cexp(1), cexp(5));
            end
        end
        tick();
    endtask

    task automatic test_saturation();
        int x [3];
        apply_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 10; c++) tick();
        extHold = 1'b0;
        tick();
        x = '{10, 10, 7};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hc[k] !== cexp(x[k])) begin errors++; $display("FAIL sat_holdCount dut%0d: got %0d want %0d", k, hc[k], cexp(x[k])); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e [3];
        apply_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        e = '{S_FLUSH, S_FLUSH, S_FLUSH};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL mid_flush dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        reset = 1'b0;
        #1;
        e = '{S_RST, S_RST, S_RST};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL mid_flush_rst dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        reset = 1'b1;
        #1;
        e = '{S_RUN, S_RUN, S_RUN};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL mid_flush_post dut%0d: got %b want %b", k, o[k], e[k]); end
            checks++;
            if ({sc[k], fc[k], hc[k]} !== 96'd0) begin errors++; $display("FAIL mid_counts dut%0d: got %0d/%0d/%0d want 0/0/0", k, sc[k], fc[k], hc[k]); end
        end
        tick();
        set_in(1, 3, 0, 0, 1, 3, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (o[2] !== S_STALL) begin errors++; $display("FAIL mid_lstall dut2: got %b want %b", o[2], S_STALL); end
        reset = 1'b0;
        #1;
        checks++;
        if (o[2] !== S_RST) begin errors++; $display("FAIL mid_lstall_rst dut2: got %b want %b", o[2], S_RST); end
        tick();
        reset = 1'b1;
        #1;
        e = '{S_RUN, S_RUN, S_RUN};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL mid_lstall_post dut%0d: got %b want %b", k, o[k], e[k]); end
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL mid_no_residual dut%0d: got %b want %b", k, o[k], e[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd2();
        test_redirect();
        test_priority();
        test_hold_lstall();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
